// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared PS/2 set-2 constants, emitter FSM state and sequence helpers
// Rev 1.0 ; GAP state exists only when ASCII2SCAN_GAP_EN is defined
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam int         GAP_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    SH_MK,
    KEY_MK,
    KEY_F0,
    KEY_BRK,
    SH_F0,
    SH_BRK
`ifdef ASCII2SCAN_GAP_EN
    , GAP
`endif
  } state_t;

  function automatic state_t seq_next(input state_t s, input logic shift);
    case (s)
      SH_MK:   seq_next = KEY_MK;
      KEY_MK:  seq_next = KEY_F0;
      KEY_F0:  seq_next = KEY_BRK;
      KEY_BRK: seq_next = shift ? SH_F0 : IDLE;
      SH_F0:   seq_next = SH_BRK;
      default: seq_next = IDLE;
    endcase
  endfunction

  // Byte presented on out_data while sitting in state s.
  function automatic logic [7:0] seq_byte(input state_t s, input logic [7:0] code);
    case (s)
      SH_MK, SH_BRK:   seq_byte = SC_LSHIFT;
      KEY_MK, KEY_BRK: seq_byte = code;
      KEY_F0, SH_F0:   seq_byte = SC_BREAK;
      default:         seq_byte = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascii_scan_lut.sv
// ============================================================================
// ascii_scan_lut : combinational ASCII -> {hit, shift, set-2 make code}
// Rev 1.0
// ============================================================================
`default_nettype none

module ascii_scan_lut (
  input  logic [7:0] ascii_i,
  output logic       hit_o,
  output logic       shift_o,
  output logic [7:0] code_o
);

  localparam logic [7:0] LETTER_CODE [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };
  localparam logic [7:0] DIGIT_CODE [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  logic [4:0] lc_idx_w;
  logic [4:0] uc_idx_w;
  logic [3:0] dg_idx_w;

  assign lc_idx_w = 5'(ascii_i - 8'h61);
  assign uc_idx_w = 5'(ascii_i - 8'h41);
  assign dg_idx_w = 4'(ascii_i - 8'h30);

  always_comb begin
    hit_o   = 1'b1;
    shift_o = 1'b0;
    code_o  = 8'h00;
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) begin
      code_o = LETTER_CODE[lc_idx_w];
    end else if (ascii_i >= 8'h41 && ascii_i <= 8'h5A) begin
      shift_o = 1'b1;
      code_o  = LETTER_CODE[uc_idx_w];
    end else if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      code_o = DIGIT_CODE[dg_idx_w];
    end else begin
      // Shifted symbols reuse the digit key they sit on.
      shift_o = 1'b1;
      case (ascii_i)
        8'h29:   code_o = DIGIT_CODE[0];
        8'h21:   code_o = DIGIT_CODE[1];
        8'h40:   code_o = DIGIT_CODE[2];
        8'h23:   code_o = DIGIT_CODE[3];
        8'h24:   code_o = DIGIT_CODE[4];
        8'h25:   code_o = DIGIT_CODE[5];
        8'h5E:   code_o = DIGIT_CODE[6];
        8'h26:   code_o = DIGIT_CODE[7];
        8'h2A:   code_o = DIGIT_CODE[8];
        8'h28:   code_o = DIGIT_CODE[9];
        8'h20: begin shift_o = 1'b0; code_o = 8'h29; end
        8'h0D: begin shift_o = 1'b0; code_o = 8'h5A; end
        default: begin hit_o = 1'b0; shift_o = 1'b0; end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ascii_to_scan.sv
// ============================================================================
// ascii_to_scan : ASCII character -> PS/2 set-2 make/break byte stream
// Rev 1.0 ; ASCII2SCAN_GAP_EN adds GAP_CYCLES idle cycles after every byte
// ============================================================================
`default_nettype none

module ascii_to_scan
  import ps2_pkg::*;
#(
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_ascii,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       err
);

  state_t     state_q;
  logic [7:0] code_q;
  logic       shift_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       err_q;

  logic       lut_hit;
  logic       lut_shift;
  logic [7:0] lut_code;
  state_t     first_d;
  state_t     next_d;

  ascii_scan_lut u_lut (
    .ascii_i (in_ascii),
    .hit_o   (lut_hit),
    .shift_o (lut_shift),
    .code_o  (lut_code)
  );

  assign first_d = lut_shift ? SH_MK : KEY_MK;
  assign next_d  = seq_next(state_q, shift_q);

`ifdef ASCII2SCAN_GAP_EN
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  state_t           ret_q;
  logic [GAP_W-1:0] cnt_q;
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = (GAP_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= 8'h00;
      shift_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      err_q       <= 1'b0;
`ifdef ASCII2SCAN_GAP_EN
      ret_q       <= IDLE;
      cnt_q       <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (lut_hit) begin
              code_q      <= lut_code;
              shift_q     <= lut_shift;
              state_q     <= first_d;
              out_valid_q <= 1'b1;
              out_data_q  <= seq_byte(first_d, lut_code);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
`ifdef ASCII2SCAN_GAP_EN
        GAP: begin
          if (cnt_q == GAP_W'(1)) begin
            state_q     <= ret_q;
            out_valid_q <= (ret_q != IDLE);
            if (ret_q != IDLE) out_data_q <= seq_byte(ret_q, code_q);
          end else begin
            cnt_q <= cnt_q - GAP_W'(1);
          end
        end
`endif
        default: begin
          // Every emitting state holds out_valid high until the handshake.
          if (out_ready) begin
`ifdef ASCII2SCAN_GAP_EN
            state_q     <= GAP;
            ret_q       <= next_d;
            cnt_q       <= GAP_LOAD;
            out_valid_q <= 1'b0;
`else
            state_q     <= next_d;
            out_valid_q <= (next_d != IDLE);
            if (next_d != IDLE) out_data_q <= seq_byte(next_d, code_q);
`endif
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/ascii_to_scan.md
Name: ascii_to_scan

Overview:
- Keyboard-side emitter for the PS/2 set-2 byte stream: takes one ASCII character per handshake and produces the make/break scan-code sequence a keyboard would send for it.
- Inserts left-Shift make/break around shifted characters.
- Feeds the on-board PS/2 decode path and its tests, and acts as a stimulus source for the keyboard receiver.

Parameters:
- GAP_CYCLES, 16, idle cycles inserted after each emitted byte. Used only when ASCII2SCAN_GAP_EN is defined; valid range 1..65535.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_ascii is valid.
- in_ready  out  1  block can accept a character.
- in_ascii  in  8  ASCII character.
- out_valid  out  1  out_data holds a scan-code byte.
- out_ready  in  1  consumer takes out_data.
- out_data  out  8  scan-code byte.
- busy  out  1  a sequence is in progress; equals !in_ready.
- err  out  1  one-cycle pulse: the accepted character is unsupported.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out_data=8'h00; busy=0; err=0. All outputs are registered or decoded from state registers only; no input-to-output combinational path.
- Accept: a character is accepted when in_valid && in_ready (IDLE only). The character is looked up in the same cycle; code and shift flag are registered.
- Character mapping, lowercase (shift=0):
  - a..z use scan codes 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - 0..9 use 45 16 1E 26 25 2E 36 3D 3E 46.
  - space 8'h20 -> 29; CR 8'h0D -> 5A.
- Character mapping, shifted (shift=1):
  - A..Z use the same codes as a..z.
  - ) ! @ # $ % ^ & * ( use the codes of 0..9 respectively.
- Unsupported characters (anything else, including 8'h80-8'hFF):
  - Accepted, no bytes emitted.
  - err=1 for exactly the cycle after acceptance; block back in IDLE (in_ready=1) that same cycle.
- Emitted sequences:
  - shift=0: code, F0, code (3 bytes).
  - shift=1: 12, code, F0, code, F0, 12 (6 bytes).
- FSM states: IDLE, SH_MK, KEY_MK, KEY_F0, KEY_BRK, SH_F0, SH_BRK (plus GAP when the option is compiled in).
  - IDLE -> SH_MK (shift) or KEY_MK (no shift) on a valid accept.
  - SH_MK -> KEY_MK -> KEY_F0 -> KEY_BRK.
  - KEY_BRK -> SH_F0 (shift) or IDLE (no shift).
  - SH_F0 -> SH_BRK -> IDLE.
  - Each non-IDLE state advances only on out_valid && out_ready.
- Latency: first byte has out_valid=1 the cycle after acceptance.
- Back-to-back bytes: on a handshake the next byte appears the following cycle with out_valid held high. After the last byte's handshake, the next cycle is IDLE with out_valid=0 and in_ready=1.
- Stall: while out_valid && !out_ready, out_data and state are held stable. out_valid never drops without a handshake.
- Input stability: in_ascii is sampled only at acceptance; later input changes have no effect.
- Reset mid-sequence: abort immediately, no break bytes emitted, all outputs return to reset values the next cycle. The consumer may observe a dangling make; this is the defined behaviour.
- out_data is don't-care-free: it holds the last emitted byte while idle.

Optional Feature:
- ASCII2SCAN_GAP_EN defined:
  - After every byte handshake (including the last), enter GAP with out_valid=0 for exactly GAP_CYCLES cycles, counted by a 16-bit down-counter.
  - The next byte, or IDLE, follows.
  - in_ready stays 0 during the trailing gap.
  - Reset clears the counter.
- Not defined: no GAP state and no counter; timing exactly as in Behaviour.

Decomposition:
- Package ps2_pkg:
  - constants SC_LSHIFT=8'h12 and SC_BREAK=8'hF0;
  - FSM state enum;
  - width constant for the gap counter.
- Sub-module ascii_scan_lut: purely combinational, in_ascii -> {hit, shift, code[7:0]}. It is reusable by other stimulus generators.
- ascii_to_scan holds the FSM, the registers and the optional gap counter.

Test Plan:
- Reset, then in_ascii=8'h61 ('a') with out_ready=1 -> bytes 1C, F0, 1C on consecutive cycles starting 1 cycle after accept; in_ready=1 one cycle after the third byte.
- in_ascii=8'h40 ('@') -> 12, 1E, F0, 1E, F0, 12; busy high throughout; err never asserted.
- 'Z' with out_ready toggling 1/0 every cycle -> same 6-byte order (12,1A,F0,1A,F0,12); out_data stable during every stall cycle; no byte dropped or duplicated.
- in_ascii=8'h7E ('~') -> err=1 for one cycle; no out_valid; next character '1' then emits 16, F0, 16.
- rst asserted after the second byte of 'Q' -> out_valid=0, in_ready=1 the next cycle; a subsequent space emits 29, F0, 29.
- With ASCII2SCAN_GAP_EN and GAP_CYCLES=3, '\r' -> 5A, [3 idle], F0, [3 idle], 5A, [3 idle], then in_ready=1.
